// File: rtl/gather_req_arbiter_if.sv
// Handshake bundle between four gather requesters, the arbiter and the DMA read engine.
// master drives requests and DMA responses; slave is the arbiter itself.
interface gather_req_arbiter_if #(
  parameter int ENTRY_WIDTH = 128,
  parameter int NUM_REQ     = 4
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*ENTRY_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           dma_rd_valid;
  logic [ENTRY_WIDTH-1:0]         dma_rd_data;
  logic [1:0]                     dma_rd_src;
  logic                           dma_rd_ready;
  logic                           dma_rd_done;
  logic [3:0]                     outstanding_cnt;

  modport master (
    output req_valid, req_data, req_last, dma_rd_ready, dma_rd_done,
    input  req_ready, dma_rd_valid, dma_rd_data, dma_rd_src, outstanding_cnt
  );

  modport slave (
    input  req_valid, req_data, req_last, dma_rd_ready, dma_rd_done,
    output req_ready, dma_rd_valid, dma_rd_data, dma_rd_src, outstanding_cnt
  );
endinterface

// File: rtl/gather_req_arbiter.sv
// Round-robin arbiter feeding gather entries from four requesters into a credit-limited
// DMA read port; a grant stays locked on one requester until its last piece is accepted.
module gather_req_lane (
  input  logic        valid,
  input  logic        sel,
  input  logic        in_grant,
  input  logic        can_accept,
  input  logic [31:0] size,
  output logic        ready,
  output logic        fire,
  output logic        size_nz
);
  assign ready   = in_grant & sel & can_accept;
  assign fire    = ready & valid;
  assign size_nz = |size;
endmodule

module gather_req_arbiter #(
  parameter int ENTRY_WIDTH     = 128,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  gather_req_arbiter_if.slave bus
);
  localparam int NUM_REQ = 4;
  localparam int SZ_LSB  = 64;

  typedef enum logic {IDLE_s, GRANT_s} state_t;

  state_t     state, state_nxt;
  logic [1:0] grant, grant_nxt;
  logic [1:0] rr_ptr, rr_nxt;
  logic [1:0] pick;

  logic                   rd_valid;
  logic [ENTRY_WIDTH-1:0] rd_data;
  logic [1:0]             rd_src;
  logic [3:0]             cnt;

  logic [NUM_REQ-1:0][ENTRY_WIDTH-1:0] entry_v;
  logic [NUM_REQ-1:0] ready_v, fire_v, size_nz_v;

  logic [4:0] inflight;
  logic       credit, can_accept, in_grant, out_xfer;
  logic       acc, acc_last, acc_load, dec;

  // The entry sitting in the output register already holds a credit.
  assign inflight   = {1'b0, cnt} + {4'b0, rd_valid};
  assign credit     = inflight < 5'(MAX_OUTSTANDING);
  assign can_accept = credit & (~rd_valid | bus.dma_rd_ready);
  assign in_grant   = (state == GRANT_s);
  assign out_xfer   = rd_valid & bus.dma_rd_ready;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign entry_v[g] = bus.req_data[g*ENTRY_WIDTH +: ENTRY_WIDTH];
    gather_req_lane u_lane (
      .valid      (bus.req_valid[g]),
      .sel        (grant == 2'(g)),
      .in_grant   (in_grant),
      .can_accept (can_accept),
      .size       (entry_v[g][SZ_LSB +: 32]),
      .ready      (ready_v[g]),
      .fire       (fire_v[g]),
      .size_nz    (size_nz_v[g])
    );
  end

  assign acc      = |fire_v;
  assign acc_last = bus.req_last[grant];
  assign acc_load = acc & size_nz_v[grant];

  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE_s: begin
        if (|bus.req_valid && credit) begin
          grant_nxt = pick;
          state_nxt = GRANT_s;
        end
      end
      GRANT_s: begin
        if (acc && acc_last) begin
          state_nxt = IDLE_s;
          rr_nxt    = grant + 2'd1;
        end
      end
      default: state_nxt = IDLE_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE_s;
      grant  <= 2'd0;
      rr_ptr <= 2'd0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Zero-size pieces complete the handshake but never reach the DMA port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_src   <= 2'd0;
    end else if (acc_load) begin
      rd_valid <= 1'b1;
      rd_data  <= entry_v[grant];
      rd_src   <= grant;
    end else if (out_xfer) begin
      rd_valid <= 1'b0;
    end
  end

  assign dec = bus.dma_rd_done & (cnt != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else begin
      case ({out_xfer, dec})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.req_ready       = ready_v;
  assign bus.dma_rd_valid    = rd_valid;
  assign bus.dma_rd_data     = rd_data;
  assign bus.dma_rd_src      = rd_src;
  assign bus.outstanding_cnt = cnt;
endmodule

// File: doc/gather_req_arbiter.md
GATHER_REQ_ARBITER -- requirements
Module: gather_req_arbiter

Interface
REQ-001 The block SHALL have parameter ENTRY_WIDTH, default 128, the gather entry width: [127:96] packet length, [95:64] piece size, [63:0] physical address.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 8, the maximum number of issued DMA reads not yet completed.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 4 bits, per-requester entry valid.
REQ-006 The block SHALL have port req_data, input, 4*ENTRY_WIDTH bits, per-requester entry; requester i occupies [i*128 +: 128].
REQ-007 The block SHALL have port req_last, input, 4 bits, marking the entry as the last piece of a WQE gather.
REQ-008 The block SHALL have port req_ready, output, 4 bits, per-requester accept.
REQ-009 The block SHALL have port dma_rd_valid, output, 1 bit, registered request valid.
REQ-010 The block SHALL have port dma_rd_data, output, ENTRY_WIDTH bits, the registered entry.
REQ-011 The block SHALL have port dma_rd_src, output, 2 bits, the requester index of the entry.
REQ-012 The block SHALL have port dma_rd_ready, input, 1 bit, DMA read engine accept.
REQ-013 The block SHALL have port dma_rd_done, input, 1 bit, a one-cycle pulse per completed read.
REQ-014 The block SHALL have port outstanding_cnt, output, 4 bits, the current in-flight count.

Function
REQ-015 An entry SHALL transfer on the input side when req_valid[i] and req_ready[i] are both high at a rising clk; the output side SHALL transfer when dma_rd_valid and dma_rd_ready are both high.
REQ-016 The FSM SHALL have exactly two states, IDLE_s and GRANT_s, and SHALL hold a 2-bit grant register and a 2-bit round-robin pointer rr_ptr.
REQ-017 In IDLE_s, when any req_valid is high and a credit is available, the block SHALL latch as grant the first valid requester searching from rr_ptr upward with wrap 3->0, and SHALL move to GRANT_s on the next edge.
REQ-018 A credit SHALL be available when outstanding_cnt + dma_rd_valid < MAX_OUTSTANDING.
REQ-019 In IDLE_s, req_ready SHALL be 0.
REQ-020 In GRANT_s, req_ready[grant] SHALL be 1 iff a credit is available and (dma_rd_valid==0 or dma_rd_ready==1); all other req_ready bits SHALL be 0.
REQ-021 An accepted entry with piece size != 0 SHALL load into the output register on the same edge, giving 1-cycle latency, with dma_rd_src = grant.
REQ-022 An accepted entry with piece size == 0 SHALL be dropped, SHALL NOT set dma_rd_valid, and SHALL consume no credit.
REQ-023 An accepted entry with req_last = 1 SHALL return the FSM to IDLE_s and set rr_ptr = grant+1 mod 4; otherwise the grant SHALL remain locked in GRANT_s.
REQ-024 dma_rd_valid and dma_rd_data SHALL hold stable until accepted; dma_rd_valid SHALL clear after acceptance unless a new entry loads on the same edge.
REQ-025 outstanding_cnt SHALL increment by 1 on an output transfer and decrement by 1 on dma_rd_done.
REQ-026 When an output transfer and dma_rd_done occur in the same cycle, outstanding_cnt SHALL be unchanged.
REQ-027 dma_rd_done arriving with outstanding_cnt == 0 SHALL be ignored, with no underflow.
REQ-028 outstanding_cnt SHALL never exceed MAX_OUTSTANDING.
REQ-029 A granted requester that deasserts req_valid mid-gather SHALL keep the grant; no other requester is served until its req_last entry is accepted.

Reset
REQ-030 While rst_n == 0, asynchronously: FSM = IDLE_s, grant = 0, rr_ptr = 0, outstanding_cnt = 0, dma_rd_valid = 0, dma_rd_data = 0, dma_rd_src = 0, req_ready = 0.
REQ-031 Reset asserted mid-gather SHALL discard the held output entry and lock; after release the block SHALL arbitrate from requester 0.

Verification
REQ-032 Requesters 0 and 2 each present one last entry (size 0x100) at cycle 0, dma_rd_ready = 1 -> src 0 issued, then src 2; rr_ptr ends at 3.
REQ-033 Requester 1 presents a 2-piece gather (last on the 2nd piece) while requester 3 is valid -> both src 1 pieces issue back-to-back before src 3.
REQ-034 MAX_OUTSTANDING = 8, no dma_rd_done, 10 entries offered -> exactly 8 issued, req_ready = 0 after that, and one dma_rd_done releases exactly one more.
REQ-035 An entry with size 0 and req_last = 1 -> req_ready pulses, no dma_rd_valid, outstanding_cnt unchanged, FSM returns to IDLE_s.
REQ-036 dma_rd_ready held low for 5 cycles -> dma_rd_data stable, no further accept; simultaneous transfer and dma_rd_done -> outstanding_cnt unchanged.
REQ-037 rst_n pulsed low while in GRANT_s with dma_rd_valid = 1 -> all outputs 0 immediately, and the next grant goes to requester 0.
